temp_convert: RTL and testbench
===============================

// Module: temp_convert
// PURPOSE
//   Downstream of the switch/KEY BCD temperature entry stage. Takes a signed
//   3-digit BCD temperature (tens.units.tenths, -99.9..+99.9) and converts it
//   F->C or C->F with a multi-cycle sequential datapath. Returns a signed
//   4-digit BCD result (hund.tens.units.tenths) to the seven_seg drivers.
//   Datapath: BCD->binary, multiply/offset, restoring divide, double-dabble.
// PARAMETERS
//   DIV_W  16  divider width; one quotient bit per cycle (DIV_W cycles)
//   BIN_W  12  binary magnitude width into double-dabble (BIN_W cycles)
// PORTS
//   clk         in   1  system clock (CLOCK_50 at top level)
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  one-cycle request; sampled only in IDLE
//   to_celsius  in   1  1: input is F, output C; 0: input is C, output F
//   in_neg      in   1  input sign (1 = negative)
//   in_tens     in   4  input tens BCD digit
//   in_units    in   4  input units BCD digit
//   in_tenths   in   4  input tenths BCD digit
//   busy        out  1  conversion in progress
//   done        out  1  one-cycle pulse; outputs valid from this cycle
//   err         out  1  last request had a non-BCD digit (>9)
//   out_neg     out  1  result sign; never set for a zero result
//   out_hund    out  4  result hundreds BCD digit (0..2)
//   out_tens    out  4  result tens BCD digit
//   out_units   out  4  result units BCD digit
//   out_tenths  out  4  result tenths BCD digit
// BEHAVIOUR
//   - Reset: state IDLE; busy=done=err=out_neg=0; all out digits 0.
//     Reset mid-conversion aborts; no done for the aborted request.
//   - Values are signed integers in tenths: N = +/-(100*tens+10*units+tenths).
//   - F->C: R = sgn(N-320) * round(5*|N-320| / 9).
//   - C->F: R = sgn(N) * round(9*|N| / 5) + 320.
//   - round(a/d) = floor((2a + d) / (2d)): halves go away from zero.
//     Rounding acts on magnitude only.
//   - States and cycles, one state per edge group:
//       IDLE  -> LOAD on start (edge sampling start sets busy=1)
//       LOAD  1 cycle:     check digits, form binary N
//       MUL   1 cycle:     form signed numerator, latch sign, 2a+d
//       DIV   DIV_W cycles: restoring divide by 2d
//       BCD   BIN_W cycles: add offset (C->F), take |R|, double-dabble
//       DONE  1 cycle:     done=1, busy=0, outputs updated -> IDLE
//   - Latency: done is high on edge 2+DIV_W+BIN_W+1 (=31 at defaults) after
//     the edge that samples start.
//   - Outputs hold their last result until the next done or reset.
//   - A start while busy is ignored; it is neither queued nor errored.
//   - Inputs are captured in LOAD. Later changes to inputs do not affect the
//     running conversion.
//   - Any digit >9: skip to DONE at the next edge. err=1, outputs all 0,
//     out_neg=0. A valid conversion clears err.
//   - Range: |numerator| <= 17987 < 2^DIV_W; |R| <= 2118 < 2^BIN_W.
//     No overflow is possible at default parameters.
// TESTING
//   1 F 98.6 (to_celsius=1) -> +037.0, done at start+31, busy low after
//   2 F 32.0 -> +000.0 with out_neg=0; F 31.9 -> -000.1 (rounding check)
//   3 F -40.0 -> C -040.0; C -40.0 (to_celsius=0) -> F -040.0
//   4 C 99.9 -> F +211.8 (out_hund=2); C -99.9 -> F -147.8
//   5 in_tens=4'hA -> err=1, outputs 0, done at start+3; next valid start
//     clears err
//   6 start pulsed mid-conversion -> ignored, single done;
//     rst at cycle 10 -> all outputs 0, no done

Source files
------------

// File: rtl/temp_convert.sv
// Signed BCD temperature converter (F->C or C->F) with a multi-cycle datapath:
// BCD->binary, scale and offset, restoring divide for rounding, double-dabble.
module temp_convert #(
    parameter int DIV_W = 16,
    parameter int BIN_W = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       to_celsius,
    input  logic       in_neg,
    input  logic [3:0] in_tens,
    input  logic [3:0] in_units,
    input  logic [3:0] in_tenths,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       out_neg,
    output logic [3:0] out_hund,
    output logic [3:0] out_tens,
    output logic [3:0] out_units,
    output logic [3:0] out_tenths
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_DIV,
        S_BCD,
        S_DONE
    } state_t;

    localparam logic [4:0] DIV_LAST = 5'(DIV_W - 1);
    localparam logic [4:0] BIN_LAST = 5'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               conv_q, conv_d;
    logic               bad_q, bad_d;
    logic               nneg_q, nneg_d;
    logic [9:0]         nmag_q, nmag_d;
    logic               sgn_q, sgn_d;
    logic [4:0]         den_q, den_d;
    logic [DIV_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic               rneg_q, rneg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               oneg_q, oneg_d;
    logic [15:0]        odig_q, odig_d;

    // Combinational scratch values
    logic [10:0]        ax;
    logic [15:0]        num;
    logic [DIV_W:0]     part;
    logic [DIV_W:0]     den_ext;
    logic [BIN_W-1:0]   qv;
    logic [BIN_W-1:0]   src;
    logic [14:0]        bcd_base;
    logic [11:0]        adj;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        conv_d   = conv_q;
        bad_d    = bad_q;
        nneg_d   = nneg_q;
        nmag_d   = nmag_q;
        sgn_d    = sgn_q;
        den_d    = den_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        oneg_d   = oneg_q;
        odig_d   = odig_q;
        ax       = '0;
        num      = '0;
        part     = '0;
        den_ext  = '0;
        qv       = '0;
        src      = '0;
        bcd_base = '0;
        adj      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end

            S_LOAD: begin
                conv_d  = to_celsius;
                nneg_d  = in_neg;
                bad_d   = (in_tens > 4'd9) || (in_units > 4'd9) || (in_tenths > 4'd9);
                nmag_d  = 10'(in_tens) * 10'd100 + 10'(in_units) * 10'd10 + 10'(in_tenths);
                state_d = S_MUL;
            end

            S_MUL: begin
                // Numerator is 2a+d so the divide by 2d rounds halves away from zero.
                if (conv_q) begin
                    if (nneg_q) begin
                        ax    = {1'b0, nmag_q} + 11'd320;
                        sgn_d = 1'b1;
                    end else if (nmag_q >= 10'd320) begin
                        ax    = {1'b0, nmag_q} - 11'd320;
                        sgn_d = 1'b0;
                    end else begin
                        ax    = 11'd320 - {1'b0, nmag_q};
                        sgn_d = 1'b1;
                    end
                    num   = 16'(ax) * 16'd10 + 16'd9;
                    den_d = 5'd18;
                end else begin
                    num   = 16'(nmag_q) * 16'd18 + 16'd5;
                    sgn_d = nneg_q;
                    den_d = 5'd10;
                end
                rem_d   = '0;
                quo_d   = DIV_W'(num);
                cnt_d   = '0;
                state_d = bad_q ? S_DONE : S_DIV;
            end

            S_DIV: begin
                part    = {rem_q, quo_q[DIV_W-1]};
                den_ext = {{(DIV_W - 4){1'b0}}, den_q};
                if (part >= den_ext) begin
                    rem_d = DIV_W'(part - den_ext);
                    quo_d = {quo_q[DIV_W-2:0], 1'b1};
                end else begin
                    rem_d = part[DIV_W-1:0];
                    quo_d = {quo_q[DIV_W-2:0], 1'b0};
                end
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = S_BCD;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_BCD: begin
                // First step applies the sign and C->F offset to the quotient.
                if (cnt_q == 5'd0) begin
                    qv = quo_q[BIN_W-1:0];
                    if (conv_q) begin
                        src    = qv;
                        rneg_d = sgn_q && (qv != '0);
                    end else if (!sgn_q) begin
                        src    = qv + BIN_W'(320);
                        rneg_d = 1'b0;
                    end else if (qv > BIN_W'(320)) begin
                        src    = qv - BIN_W'(320);
                        rneg_d = 1'b1;
                    end else begin
                        src    = BIN_W'(320) - qv;
                        rneg_d = 1'b0;
                    end
                    bcd_base = '0;
                end else begin
                    src      = bin_q;
                    bcd_base = bcd_q[14:0];
                end
                for (int i = 0; i < 3; i++) begin
                    adj[i*4 +: 4] = (bcd_base[i*4 +: 4] >= 4'd5) ?
                                    bcd_base[i*4 +: 4] + 4'd3 : bcd_base[i*4 +: 4];
                end
                bcd_d = {bcd_base[14:12], adj, src[BIN_W-1]};
                bin_d = {src[BIN_W-2:0], 1'b0};
                if (cnt_q == BIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = bad_q;
                oneg_d  = bad_q ? 1'b0 : rneg_q;
                odig_d  = bad_q ? 16'h0000 : bcd_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            conv_q  <= 1'b0;
            bad_q   <= 1'b0;
            nneg_q  <= 1'b0;
            nmag_q  <= '0;
            sgn_q   <= 1'b0;
            den_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            oneg_q  <= 1'b0;
            odig_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            conv_q  <= conv_d;
            bad_q   <= bad_d;
            nneg_q  <= nneg_d;
            nmag_q  <= nmag_d;
            sgn_q   <= sgn_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            oneg_q  <= oneg_d;
            odig_q  <= odig_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign out_neg    = oneg_q;
    assign out_hund   = odig_q[15:12];
    assign out_tens   = odig_q[11:8];
    assign out_units  = odig_q[7:4];
    assign out_tenths = odig_q[3:0];

endmodule

// File: tb/tb_temp_convert.sv
// Directed bench for temp_convert: arithmetic model of the conversion rules,
// per-cycle output compare, latency, busy, abort-on-reset and ignored-start checks.
module tb_temp_convert;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       to_celsius = 1'b0;
  logic       in_neg = 1'b0;
  logic [3:0] in_tens = '0;
  logic [3:0] in_units = '0;
  logic [3:0] in_tenths = '0;
  logic       busy, done, err, out_neg;
  logic [3:0] out_hund, out_tens, out_units, out_tenths;

  int n_vec = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] cur_exp = '0;
  logic [17:0] dut_word;

  temp_convert dut (
    .clk(clk), .rst(rst), .start(start), .to_celsius(to_celsius),
    .in_neg(in_neg), .in_tens(in_tens), .in_units(in_units), .in_tenths(in_tenths),
    .busy(busy), .done(done), .err(err), .out_neg(out_neg),
    .out_hund(out_hund), .out_tens(out_tens), .out_units(out_units),
    .out_tenths(out_tenths)
  );

  always #5 clk = ~clk;

  assign dut_word = {err, out_neg, out_hund, out_tens, out_units, out_tenths};

  // Expected {err, neg, hund, tens, units, tenths} from the conversion formulas.
  function automatic logic [17:0] model(input bit toc, input bit neg,
                                        input int t, input int u, input int th);
    int n, x, a, q, r, m;
    if (t > 9 || u > 9 || th > 9) return 18'h20000;
    n = 100 * t + 10 * u + th;
    if (neg) n = -n;
    if (toc) begin
      x = n - 320;
      a = 5 * ((x < 0) ? -x : x);
      q = (2 * a + 9) / 18;
      r = (x < 0) ? -q : q;
    end else begin
      a = 9 * ((n < 0) ? -n : n);
      q = (2 * a + 5) / 10;
      r = ((n < 0) ? -q : q) + 320;
    end
    m = (r < 0) ? -r : r;
    return {1'b0, (r < 0), 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle compare: outputs must always equal the last expected result.
  always @(negedge clk) begin
    if (rst) begin
      cur_exp = '0;
    end else if (done) begin
      check("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    end
    check("outputs", 32'(dut_word), 32'(cur_exp));
  end

  task automatic run_conv(input bit toc, input bit neg, input int t, input int u,
                          input int th, input int want_lat, input bit mid_start);
    int lat;
    exp_q.push_back(model(toc, neg, t, u, th));
    @(negedge clk);
    to_celsius = toc;
    in_neg     = neg;
    in_tens    = 4'(t);
    in_units   = 4'(u);
    in_tenths  = 4'(th);
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_set", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        to_celsius = 1'($urandom_range(0, 1));
        in_neg     = 1'($urandom_range(0, 1));
        in_tens    = 4'($urandom_range(0, 15));
        in_units   = 4'($urandom_range(0, 15));
        in_tenths  = 4'($urandom_range(0, 15));
      end
      if (mid_start && k == 5) start = 1'b1;
      if (mid_start && k == 6) start = 1'b0;
      if (done) lat = k;
    end
    check("latency", 32'(lat), 32'(want_lat));
    check("busy_clear", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {13'd0, busy, done, dut_word}, 32'd0);
    rst = 1'b0;

    check("model_98_6F", 32'(model(1, 0, 9, 8, 6)), 32'h00370);
    check("model_31_9F", 32'(model(1, 0, 3, 1, 9)), 32'h10001);
    check("model_99_9C", 32'(model(0, 0, 9, 9, 9)), 32'h02118);
    check("model_m99_9C", 32'(model(0, 1, 9, 9, 9)), 32'h11478);

    run_conv(1, 0, 9, 8, 6, 31, 0);
    run_conv(1, 0, 3, 2, 0, 31, 0);
    run_conv(1, 0, 3, 1, 9, 31, 0);
    run_conv(1, 1, 4, 0, 0, 31, 0);
    run_conv(0, 1, 4, 0, 0, 31, 0);
    run_conv(0, 0, 9, 9, 9, 31, 0);
    run_conv(0, 1, 9, 9, 9, 31, 0);
    run_conv(0, 0, 0, 0, 0, 31, 0);
    run_conv(1, 1, 0, 0, 0, 31, 0);
    run_conv(1, 0, 10, 0, 0, 3, 0);
    run_conv(1, 0, 5, 0, 0, 31, 0);
    run_conv(0, 0, 3, 7, 0, 31, 1);
    run_conv(1, 0, 0, 0, 15, 3, 0);
    repeat (40) @(posedge clk);

    // Reset at cycle 10 of a conversion: aborts with no done.
    @(negedge clk);
    to_celsius = 1'b1;
    in_neg     = 1'b0;
    in_tens    = 4'd9;
    in_units   = 4'd8;
    in_tenths  = 4'd6;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_abort", {13'd0, busy, done, dut_word}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);

    run_conv(0, 0, 2, 5, 0, 31, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
